// File: rtl/ltc2387_rx.sv
// LTC2387 two-lane DDR LVDS capture controller and deserializer.
// Runs entirely on fast_clk: it issues cnv, bursts the gated read clock,
// oversamples dco/da/db and rebuilds each sample.
// Ports:
//   fast_clk, reset      sole clock, async active-high reset
//   enable               run free-running conversions
//   cnv, clk             conversion start and gated read clock to the ADC
//   dco, da, db          data clock and lanes returned by the ADC
//   sample_data          last assembled sample
//   sample_valid         one-cycle strobe, sample_data is new
//   sample_err           one-cycle strobe, read did not complete
//   busy                 high from cnv rise until the valid/err strobe
module ltc2387_rx #(
   parameter int ADC_WIDTH  = 18,
   parameter int CNV_PERIOD = 64,
   parameter int CNV_HIGH   = 2,
   parameter int T_CONV     = 20,
   parameter int CLK_HALF   = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                 fast_clk,
   input  logic                 reset,
   input  logic                 enable,
   output logic                 cnv,
   output logic                 clk,
   input  logic                 dco,
   input  logic                 da,
   input  logic                 db,
   output logic [ADC_WIDTH-1:0] sample_data,
   output logic                 sample_valid,
   output logic                 sample_err,
   output logic                 busy
);

   localparam int PAIRS  = ADC_WIDTH / 2;
   localparam int NTOG   = PAIRS - 1;
   // clk always finishes low, so an odd toggle count is padded by one
   localparam int NTOG_E = NTOG + (NTOG % 2);
   localparam int WINDOW = CNV_HIGH + T_CONV + NTOG_E * CLK_HALF
                           + TIMEOUT + 4;

   localparam int PW = $clog2(CNV_PERIOD + 1);
   localparam int HW = $clog2(CLK_HALF + 1);
   localparam int TW = $clog2(NTOG_E + 1);
   localparam int DW = $clog2(TIMEOUT + 1);

   localparam logic [PW-1:0] P_CNV_END  = PW'(CNV_HIGH - 1);
   localparam logic [PW-1:0] P_WAIT_END = PW'(CNV_HIGH + T_CONV - 1);
   localparam logic [PW-1:0] P_LAST     = PW'(CNV_PERIOD - 1);
   localparam logic [HW-1:0] H_LAST     = HW'(CLK_HALF - 1);
   localparam logic [TW-1:0] T_LAST     = TW'(NTOG_E - 1);
   localparam logic [TW-1:0] T_NTOG     = TW'(NTOG);
   localparam logic [DW-1:0] D_LAST     = DW'(TIMEOUT - 1);

   if (ADC_WIDTH < 4 || (ADC_WIDTH % 2) != 0) begin : g_bad_width
      $error("ltc2387_rx: ADC_WIDTH must be even and >= 4");
   end
   if (CLK_HALF < 2) begin : g_bad_half
      $error("ltc2387_rx: CLK_HALF must be >= 2");
   end
   if (WINDOW > CNV_PERIOD) begin : g_bad_window
      $error("ltc2387_rx: read window does not fit in CNV_PERIOD");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_CNV, S_WAIT, S_BURST, S_DRAIN, S_HOLD
   } state_t;

   state_t state, state_n;

   logic [PW-1:0]        period_cnt;
   logic [HW-1:0]        half_cnt;
   logic [TW-1:0]        clk_tgl;
   logic [TW-1:0]        tog_cnt;
   logic [TW-1:0]        cap_cnt;
   logic [DW-1:0]        drain_cnt;
   logic [ADC_WIDTH-1:0] shift;
   logic                 cap_pend;

   logic dco_s1, dco_s2, dco_s3;
   logic da_s1, da_s2, da_s3;
   logic db_s1, db_s2, db_s3;

   logic start, burst_go, clk_flip, done_ok, done_err;
   logic cap_act, tog_hit;

   assign cnv     = (state == S_CNV);
   assign cap_act = (state == S_BURST) || (state == S_DRAIN);
   assign tog_hit = cap_act && (dco_s2 != dco_s3) && (tog_cnt != T_NTOG);

   always_comb begin
      state_n  = state;
      start    = 1'b0;
      burst_go = 1'b0;
      clk_flip = 1'b0;
      done_ok  = 1'b0;
      done_err = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (enable) begin
               state_n = S_CNV;
               start   = 1'b1;
            end
         end
         S_CNV: begin
            if (period_cnt == P_CNV_END) state_n = S_WAIT;
         end
         S_WAIT: begin
            if (period_cnt == P_WAIT_END) begin
               state_n  = S_BURST;
               burst_go = 1'b1;
            end
         end
         S_BURST: begin
            if (half_cnt == H_LAST) begin
               clk_flip = 1'b1;
               if (clk_tgl == T_LAST) state_n = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (cap_cnt == T_NTOG) begin
               done_ok = 1'b1;
               state_n = S_HOLD;
            end else if (drain_cnt == D_LAST) begin
               done_err = 1'b1;
               state_n  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (period_cnt == P_LAST) begin
               if (enable) begin
                  state_n = S_CNV;
                  start   = 1'b1;
               end else begin
                  state_n = S_IDLE;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge fast_clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         period_cnt   <= '0;
         half_cnt     <= '0;
         clk_tgl      <= '0;
         tog_cnt      <= '0;
         cap_cnt      <= '0;
         drain_cnt    <= '0;
         shift        <= '0;
         cap_pend     <= 1'b0;
         clk          <= 1'b0;
         busy         <= 1'b0;
         sample_data  <= '0;
         sample_valid <= 1'b0;
         sample_err   <= 1'b0;
         {dco_s3, dco_s2, dco_s1} <= '0;
         {da_s3, da_s2, da_s1}    <= '0;
         {db_s3, db_s2, db_s1}    <= '0;
      end else begin
         {dco_s3, dco_s2, dco_s1} <= {dco_s2, dco_s1, dco};
         {da_s3, da_s2, da_s1}    <= {da_s2, da_s1, da};
         {db_s3, db_s2, db_s1}    <= {db_s2, db_s1, db};

         state <= state_n;

         if (state == S_IDLE || period_cnt == P_LAST) period_cnt <= '0;
         else period_cnt <= period_cnt + 1'b1;

         sample_valid <= done_ok;
         sample_err   <= done_err;
         if (done_ok) sample_data <= shift;

         if (start) busy <= 1'b1;
         else if (done_ok || done_err) busy <= 1'b0;

         if (burst_go) begin
            clk      <= 1'b1;
            clk_tgl  <= TW'(1);
            half_cnt <= '0;
         end else if (state == S_BURST) begin
            if (clk_flip) begin
               clk      <= ~clk;
               clk_tgl  <= clk_tgl + 1'b1;
               half_cnt <= '0;
            end else begin
               half_cnt <= half_cnt + 1'b1;
            end
         end

         if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
         else drain_cnt <= '0;

         // pair 0 sits at the bottom and is shifted up by each later pair,
         // landing in the MSBs once all NTOG pairs have arrived
         if (burst_go) begin
            shift    <= {{(ADC_WIDTH-2){1'b0}}, da_s2, db_s2};
            tog_cnt  <= '0;
            cap_cnt  <= '0;
            cap_pend <= 1'b0;
         end else begin
            cap_pend <= tog_hit;
            if (tog_hit) tog_cnt <= tog_cnt + 1'b1;
            if (cap_pend) begin
               shift   <= {shift[ADC_WIDTH-3:0], da_s3, db_s3};
               cap_cnt <= cap_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ltc2387_rx.sv
// Scoreboard bench for ltc2387_rx with a behavioural LTC2387 model.
// Expected samples are queued at each cnv rise and checked at each strobe.
module tb_ltc2387_rx;

   localparam int W        = 18;
   localparam int NT       = 8;
   localparam int CNV_HIGH = 2;
   localparam int T_CONV   = 20;
   localparam int PERIOD   = 64;

   logic         fast_clk = 1'b0;
   logic         reset    = 1'b1;
   logic         enable   = 1'b0;
   logic         cnv, clk;
   logic         dco = 1'b0;
   logic         da  = 1'b0;
   logic         db  = 1'b0;
   logic [W-1:0] sample_data;
   logic         sample_valid, sample_err, busy;

   ltc2387_rx #(
      .ADC_WIDTH (W),
      .CNV_PERIOD(PERIOD),
      .CNV_HIGH  (CNV_HIGH),
      .T_CONV    (T_CONV),
      .CLK_HALF  (2),
      .TIMEOUT   (16)
   ) dut (
      .fast_clk    (fast_clk),
      .reset       (reset),
      .enable      (enable),
      .cnv         (cnv),
      .clk         (clk),
      .dco         (dco),
      .da          (da),
      .db          (db),
      .sample_data (sample_data),
      .sample_valid(sample_valid),
      .sample_err  (sample_err),
      .busy        (busy)
   );

   always #5 fast_clk = ~fast_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h",
                  name, $time, got, exp);
      end
   endtask

   typedef struct {
      bit           err;
      logic [W-1:0] data;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         push_e;
   logic [W-1:0] adc_word  = '0;
   logic [W-1:0] cur_word  = '0;
   logic [W-1:0] last_good = '0;
   logic [W-1:0] pair;
   bit           model_on  = 1'b1;
   bit           cur_on    = 1'b0;
   bit           cnv_seen  = 1'b0;
   int           extra     = 0;
   int           edge_n    = 0;
   logic [31:0]  rnd;

   // ADC model: each cnv latches a word; after cnv falls the MSB pair is
   // presented, then every clk edge toggles dco with the next pair.
   always @(clk or cnv) begin
      if (cnv) begin
         if (!cnv_seen) begin
            cnv_seen  = 1'b1;
            cur_word  = adc_word;
            cur_on    = model_on;
            edge_n    = 0;
            if (cur_on) last_good = cur_word;
            push_e.err  = !cur_on;
            push_e.data = last_good;
            exp_q.push_back(push_e);
         end
      end else if (cnv_seen) begin
         cnv_seen = 1'b0;
         if (cur_on) begin
            #3;
            da = cur_word[W-1];
            db = cur_word[W-2];
         end
      end else if (cur_on && edge_n < NT) begin
         edge_n++;
         #2;
         pair = cur_word >> (W - 2 - 2 * edge_n);
         dco  = ~dco;
         da   = pair[1];
         db   = pair[0];
         if (edge_n == NT) begin
            repeat (extra) begin
               #20;
               rnd = $urandom;
               dco = ~dco;
               da  = rnd[0];
               db  = rnd[1];
            end
         end
      end
   end

   int cyc        = 0;
   int rise_cyc   = 0;
   int cnv_hi     = 0;
   int clk_rises  = 0;
   int clk_total  = 0;
   int first_rise = -1;
   int cnv_rises  = 0;
   int strobe_cnt = 0;
   int disturb    = 0;
   int seen_dist  = 0;
   bit have_rise  = 1'b0;
   bit p_cnv      = 1'b0;
   bit p_clk      = 1'b0;
   exp_t got_e;

   always @(negedge fast_clk) begin
      cyc++;
      if (cnv && !p_cnv) begin
         if (have_rise && seen_dist == disturb)
            chk("cnv_period", cyc - rise_cyc, PERIOD);
         have_rise  = 1'b1;
         seen_dist  = disturb;
         rise_cyc   = cyc;
         cnv_hi     = 0;
         clk_rises  = 0;
         first_rise = -1;
         cnv_rises++;
      end
      if (cnv) cnv_hi++;
      if (clk && !p_clk) begin
         clk_rises++;
         clk_total++;
         if (first_rise < 0) first_rise = cyc - rise_cyc;
      end
      if (sample_valid || sample_err) begin
         strobe_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe at %0t: valid=%0b err=%0b",
                     $time, sample_valid, sample_err);
         end else begin
            got_e = exp_q.pop_front();
            chk("strobe_kind", {30'd0, sample_valid, sample_err},
                got_e.err ? 32'd1 : 32'd2);
            chk("sample_data", 32'(sample_data), 32'(got_e.data));
            chk("busy_at_strobe", 32'(busy), 32'd0);
            chk("cnv_high_cycles", cnv_hi, CNV_HIGH);
            chk("clk_pulses", clk_rises, NT / 2);
            chk("first_clk_offset", first_rise, CNV_HIGH + T_CONV);
         end
      end
      p_cnv = cnv;
      p_clk = clk;
   end

   task automatic wait_strobes(input int n, input int limit);
      int target;
      int t;
      target = strobe_cnt + n;
      t = 0;
      while (strobe_cnt < target && t < limit) begin
         @(negedge fast_clk);
         t++;
      end
      checks++;
      if (strobe_cnt < target) begin
         errors++;
         $display("FAIL strobe_wait at %0t: got %0d strobes expected %0d",
                  $time, strobe_cnt - (target - n), n);
      end
   endtask

   task automatic wait_clk_high(input int limit);
      int t;
      t = 0;
      while (clk !== 1'b1 && t < limit) begin
         @(negedge fast_clk);
         t++;
      end
      chk("clk_high_seen", 32'(clk), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cnv"}, 32'(cnv), 0);
      chk({tag, "_clk"}, 32'(clk), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_valid"}, 32'(sample_valid), 0);
      chk({tag, "_err"}, 32'(sample_err), 0);
      chk({tag, "_data"}, 32'(sample_data), 0);
   endtask

   int snap_cnv;
   int snap_clk;

   initial begin
      adc_word = 18'h3FFFF;
      repeat (3) @(negedge fast_clk);
      chk_all_zero("reset");

      reset  = 1'b0;
      enable = 1'b1;
      wait_strobes(3, 300);

      adc_word = 18'b110011001100110011;
      wait_strobes(1, 100);
      adc_word = 18'b010101010101010101;
      wait_strobes(1, 100);
      chk("lane_order_data", 32'(sample_data), 32'h15555);

      for (int i = 0; i < 6; i++) begin
         rnd      = $urandom;
         adc_word = rnd[W-1:0];
         wait_strobes(1, 100);
      end

      model_on = 1'b0;
      wait_strobes(2, 200);
      model_on = 1'b1;
      rnd      = $urandom;
      adc_word = rnd[W-1:0];
      wait_strobes(1, 100);

      extra = 2;
      for (int i = 0; i < 2; i++) begin
         rnd      = $urandom;
         adc_word = rnd[W-1:0];
         wait_strobes(1, 100);
      end
      extra = 0;

      rnd      = $urandom;
      adc_word = rnd[W-1:0];
      wait_clk_high(200);
      chk("busy_in_burst", 32'(busy), 32'd1);
      enable = 1'b0;
      disturb++;
      wait_strobes(1, 100);
      snap_cnv = cnv_rises;
      snap_clk = clk_total;
      repeat (150) @(negedge fast_clk);
      chk("idle_no_cnv", cnv_rises, snap_cnv);
      chk("idle_no_clk", clk_total, snap_clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_cnv_level", 32'(cnv), 32'd0);

      enable = 1'b1;
      wait_clk_high(200);
      repeat (3) @(negedge fast_clk);
      reset = 1'b1;
      disturb++;
      #1;
      chk_all_zero("midburst");
      exp_q.delete();
      rnd      = $urandom;
      adc_word = rnd[W-1:0];
      repeat (3) @(negedge fast_clk);
      reset = 1'b0;
      @(posedge fast_clk);
      #1;
      chk("cnv_after_reset", 32'(cnv), 32'd1);
      wait_strobes(2, 300);

      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
